// File: rtl/cci_mpf_prim_ram_simple_multi.sv
// rtl/cci_mpf_prim_ram_simple_multi.sv - single-write, multi-read RAM with self-initialization
//
// One storage copy per read port. Every write goes to all copies, so the read
// ports are fully independent. After reset the block writes INIT_VALUE to every
// word, one word per cycle, and raises rdy when the last word is written.
//
// Optional feature macro: CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
//   defined   : write-to-read bypass. A write at the read edge, or at any later
//               edge while the read is still in its pipeline, supplies the data.
//   undefined : a read and a write to the same address at one edge return old data.
//
// Ports:
//   clk      - sole clock
//   reset_n  - asynchronous active-low reset
//   rdy      - high once initialization is complete
//   wen      - write enable
//   waddr    - write address
//   wdata    - write data
//   ren      - per-port read request
//   raddr    - per-port read address
//   rvalid   - per-port read response valid, one cycle per request
//   rdata    - per-port read data, meaningful only while rvalid is high
module cci_mpf_prim_ram_simple_multi #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_READ_PORTS = 2,
    parameter int N_OUTPUT_REG_STAGES = 0,
    parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                                               clk,
    input  logic                                               reset_n,
    output logic                                               rdy,
    input  logic                                               wen,
    input  logic [$clog2(N_ENTRIES)-1:0]                       waddr,
    input  logic [N_DATA_BITS-1:0]                             wdata,
    input  logic [N_READ_PORTS-1:0]                            ren,
    input  logic [N_READ_PORTS-1:0][$clog2(N_ENTRIES)-1:0]     raddr,
    output logic [N_READ_PORTS-1:0]                            rvalid,
    output logic [N_READ_PORTS-1:0][N_DATA_BITS-1:0]           rdata
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int S  = N_OUTPUT_REG_STAGES;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  init_addr, init_addr_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= init_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_addr_nxt = init_addr;
        if (state == ST_INIT) begin
            init_addr_nxt = init_addr + 1'b1;
            if (init_addr == AW'(N_ENTRIES - 1)) begin
                state_nxt     = ST_READY;
                init_addr_nxt = '0;
            end
        end
    end

    assign rdy = (state == ST_READY);

    // User writes count only once ready and only when the address exists;
    // this qualified strobe also gates the bypass so dropped writes never forward.
    logic                   wr_ok;
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [N_DATA_BITS-1:0] mem_wdata;

    assign wr_ok     = rdy && wen && (32'(waddr) < 32'(N_ENTRIES));
    assign mem_we    = (state == ST_INIT) || wr_ok;
    assign mem_waddr = (state == ST_INIT) ? init_addr : waddr;
    assign mem_wdata = (state == ST_INIT) ? INIT_VALUE : wdata;

    for (genvar p = 0; p < N_READ_PORTS; p++) begin : g_port
        logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
        logic                   rd_in_range;
        logic [N_DATA_BITS-1:0] rd_word;
        logic [N_DATA_BITS-1:0] d0_nxt;
        logic [S:0]             v;
        logic [N_DATA_BITS-1:0] d [S+1];
`ifdef CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
        logic [AW-1:0]          a [S+1];
`endif

        // Contents are never reset; the init sweep defines them.
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
        end

        assign rd_in_range = 32'(raddr[p]) < 32'(N_ENTRIES);
        assign rd_word     = rd_in_range ? mem[raddr[p]] : '0;

`ifdef CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
        assign d0_nxt = (wr_ok && (waddr == raddr[p])) ? wdata : rd_word;
`else
        assign d0_nxt = rd_word;
`endif

        // Only the valid bits are reset, which is enough to drop in-flight reads.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v <= '0;
            end else begin
                v[0] <= ren[p] && rdy;
                for (int s = 1; s <= S; s++) begin
                    v[s] <= v[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            d[0] <= d0_nxt;
`ifdef CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
            a[0] <= raddr[p];
`endif
            for (int s = 1; s <= S; s++) begin
                d[s] <= d[s-1];
`ifdef CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
                a[s] <= a[s-1];
                // A later write to the same word overtakes the data as it moves
                // down the pipe; the newest write reaches the output last.
                if (wr_ok && (waddr == a[s-1])) begin
                    d[s] <= wdata;
                end
`endif
            end
        end

        assign rvalid[p] = v[S];
        assign rdata[p]  = d[S];
    end

endmodule

// File: tb/tb_cci_mpf_prim_ram_simple_multi.sv
// tb/tb_cci_mpf_prim_ram_simple_multi.sv - scoreboard bench for cci_mpf_prim_ram_simple_multi
module tb_cci_mpf_prim_ram_simple_multi;

    localparam int L  = 3;    // main instance: N_OUTPUT_REG_STAGES = 2
    localparam int L2 = 1;    // range instance: no output stages

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic              rdy;
    logic              wen = 1'b0;
    logic [4:0]        waddr = '0;
    logic [63:0]       wdata = '0;
    logic [1:0]        ren = '0;
    logic [1:0][4:0]   raddr = '0;
    logic [1:0]        rvalid;
    logic [1:0][63:0]  rdata;

    logic              rdy2;
    logic              wen2 = 1'b0;
    logic [4:0]        waddr2 = '0;
    logic [63:0]       wdata2 = '0;
    logic [0:0]        ren2 = '0;
    logic [0:0][4:0]   raddr2 = '0;
    logic [0:0]        rvalid2;
    logic [0:0][63:0]  rdata2;

    cci_mpf_prim_ram_simple_multi #(
        .N_ENTRIES(32), .N_DATA_BITS(64), .N_READ_PORTS(2),
        .N_OUTPUT_REG_STAGES(2), .INIT_VALUE(64'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rvalid(rvalid), .rdata(rdata)
    );

    cci_mpf_prim_ram_simple_multi #(
        .N_ENTRIES(24), .N_DATA_BITS(64), .N_READ_PORTS(1),
        .N_OUTPUT_REG_STAGES(0), .INIT_VALUE(64'h5A)
    ) dut_oor (
        .clk(clk), .reset_n(reset_n), .rdy(rdy2),
        .wen(wen2), .waddr(waddr2), .wdata(wdata2),
        .ren(ren2), .raddr(raddr2), .rvalid(rvalid2), .rdata(rdata2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever an rvalid is seen; flag late/missing ones.
    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) begin
            if (q0.size() == 0) chk("p0_spurious_rvalid", 64'(rvalid[0]), 64'd0);
            else begin
                chk("p0_rdata", rdata[0], q0[0].d);
                chk("p0_latency", 64'(cyc), 64'(q0[0].c));
                void'(q0.pop_front());
            end
        end else if (q0.size() > 0 && q0[0].c <= cyc) begin
            chk("p0_missing_rvalid", 64'(rvalid[0]), 64'd1);
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rvalid[1] === 1'b1) begin
            if (q1.size() == 0) chk("p1_spurious_rvalid", 64'(rvalid[1]), 64'd0);
            else begin
                chk("p1_rdata", rdata[1], q1[0].d);
                chk("p1_latency", 64'(cyc), 64'(q1[0].c));
                void'(q1.pop_front());
            end
        end else if (q1.size() > 0 && q1[0].c <= cyc) begin
            chk("p1_missing_rvalid", 64'(rvalid[1]), 64'd1);
            void'(q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rvalid2[0] === 1'b1) begin
            if (q2.size() == 0) chk("oor_spurious_rvalid", 64'(rvalid2[0]), 64'd0);
            else begin
                chk("oor_rdata", rdata2[0], q2[0].d);
                chk("oor_latency", 64'(cyc), 64'(q2[0].c));
                void'(q2.pop_front());
            end
        end else if (q2.size() > 0 && q2[0].c <= cyc) begin
            chk("oor_missing_rvalid", 64'(rvalid2[0]), 64'd1);
            void'(q2.pop_front());
        end
    end

    // One cycle on the main instance, called at a negedge; returns at the next negedge.
    task automatic drive(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [63:0] e0, input logic [63:0] e1);
        wen = w; waddr = wa; wdata = wd; ren = r;
        raddr[0] = a0; raddr[1] = a1;
        if (r[0]) q0.push_back(exp_t'{d: e0, c: cyc + L});
        if (r[1]) q1.push_back(exp_t'{d: e1, c: cyc + L});
        @(negedge clk);
        wen = 1'b0; ren = '0;
    endtask

    task automatic drive2(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                          input logic r, input logic [4:0] ra, input logic [63:0] e);
        wen2 = w; waddr2 = wa; wdata2 = wd; ren2[0] = r; raddr2[0] = ra;
        if (r) q2.push_back(exp_t'{d: e, c: cyc + L2});
        @(negedge clk);
        wen2 = 1'b0; ren2 = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Releases reset at a negedge and returns the number of edges until rdy.
    // User traffic in the first cycle must be ignored while initializing.
    task automatic release_and_time(output int edges);
        reset_n = 1'b1;
        wen = 1'b1; waddr = 5'd3; wdata = 64'h77; ren = 2'b11;
        raddr[0] = 5'd3; raddr[1] = 5'd4;
        @(negedge clk);
        wen = 1'b0; ren = '0;
        edges = 1;
        while (rdy !== 1'b1 && edges < 100) begin
            chk("rdy_low_during_init", 64'(rdy), 64'd0);
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_coll;
        logic [63:0] exp_byp;
`ifdef CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN
        exp_coll = 64'hBEEF;
        exp_byp  = 64'h2;
`else
        exp_coll = 64'h11;
        exp_byp  = 64'h5;
`endif
        idle(3);
        chk("reset_rdy", 64'(rdy), 64'd0);
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rdy2", 64'(rdy2), 64'd0);

        // Init timing: rdy rises exactly 32 edges after release.
        release_and_time(t);
        chk("init_cycles", 64'(t), 64'd32);
        for (int a = 0; a < 32; a++)
            drive(1'b0, 5'd0, 64'd0, 2'b11, 5'(a), 5'(31 - a), 64'hA5, 64'hA5);
        idle(4);

        // Latency: write then read two cycles later on port 1 only.
        drive(1'b1, 5'd5, 64'h1234, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 2'b10, 5'd0, 5'd5, 64'd0, 64'h1234);
        idle(4);

        // Collision: same-edge write and read of address 7.
        drive(1'b1, 5'd7, 64'h11, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b1, 5'd7, 64'hBEEF, 2'b11, 5'd7, 5'd6, exp_coll, 64'hA5);
        drive(1'b0, 5'd0, 64'd0, 2'b10, 5'd0, 5'd7, 64'd0, 64'hBEEF);
        idle(4);

        // Pipeline bypass: read 9, then two writes while the read is in flight.
        drive(1'b1, 5'd9, 64'h5, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd9, 5'd5, exp_byp, 64'h1234);
        drive(1'b1, 5'd9, 64'h1, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b1, 5'd9, 64'h2, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd9, 5'd9, 64'h2, 64'h2);
        idle(4);

        // Reset mid-flight: in-flight reads are dropped and contents reinitialized.
        drive(1'b1, 5'd10, 64'h33, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd10, 5'd10, 64'h33, 64'h33);
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        release_and_time(t);
        chk("reinit_cycles", 64'(t), 64'd32);
        drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd10, 5'd9, 64'hA5, 64'hA5);
        drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd7, 5'd5, 64'hA5, 64'hA5);
        idle(4);

        // Out of range on the 24-entry instance.
        chk("oor_rdy", 64'(rdy2), 64'd1);
        drive2(1'b1, 5'd30, 64'hFF, 1'b0, 5'd0, 64'd0);
        drive2(1'b0, 5'd0, 64'd0, 1'b1, 5'd30, 64'd0);
        for (int a = 0; a < 24; a++)
            drive2(1'b0, 5'd0, 64'd0, 1'b1, 5'(a), 64'h5A);
        idle(6);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cci_mpf_prim_ram_simple_multi.md
CCI_MPF_PRIM_RAM_SIMPLE_MULTI -- requirements
Module: cci_mpf_prim_ram_simple_multi

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_ENTRIES, 32, number of words; any value >= 2.
- N_DATA_BITS, 64, word width.
- N_READ_PORTS, 2, independent read ports; range 1..4.
- N_OUTPUT_REG_STAGES, 0, extra read register stages; range 0..3.
- INIT_VALUE, 0, value written to every word during initialization.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock.
- reset_n, input, 1, asynchronous active-low reset.
- rdy, output, 1, high once initialization is complete.
- wen, input, 1, write enable.
- waddr, input, $clog2(N_ENTRIES), write address.
- wdata, input, N_DATA_BITS, write data.
- ren, input, N_READ_PORTS, per-port read request.
- raddr, input, N_READ_PORTS x $clog2(N_ENTRIES), per-port read address.
- rvalid, output, N_READ_PORTS, per-port read response valid.
- rdata, output, N_READ_PORTS x N_DATA_BITS, per-port read data.

Function
REQ-003 The block SHALL be a single-write, N_READ_PORTS-read RAM: one storage copy per read port, with every write broadcast to all copies.
REQ-004 Read latency SHALL be L = 1 + N_OUTPUT_REG_STAGES cycles: a request with ren[p]=1 sampled at edge T SHALL produce rvalid[p]=1 with its rdata[p] after edge T+L-1, valid for exactly one cycle.
REQ-005 Each port SHALL accept one request per cycle, fully pipelined, with no backpressure; ports SHALL be mutually independent.
REQ-006 rdata[p] SHALL be don't-care whenever rvalid[p]=0.
REQ-007 The init FSM SHALL have two states, INIT and READY.
- INIT: write INIT_VALUE to address 0, 1, ... N_ENTRIES-1, one address per cycle.
- Transition to READY on the edge that writes address N_ENTRIES-1.
- rdy SHALL equal (state == READY).
REQ-008 While in INIT, wen and ren SHALL be ignored: user writes are dropped, no rvalid is generated, and nothing is queued.
REQ-009 A write with waddr >= N_ENTRIES SHALL be dropped; a read with raddr >= N_ENTRIES SHALL return rvalid=1 with rdata=0.
REQ-010 With the bypass disabled, a read and a write to the same address at the same edge SHALL return the old data (mixed-port OLD_DATA); the write is visible to reads issued at later edges.

Reset
REQ-011 Asserting reset_n=0 SHALL asynchronously force the state to INIT, rdy=0, all rvalid=0, and clear the init address counter and every read-pipeline valid bit.
REQ-012 Reset deassertion mid-operation SHALL restart full initialization; responses in flight at reset SHALL be discarded and never emitted.
REQ-013 Memory contents SHALL NOT be reset directly; they become defined only when reinitialization completes.

Configuration
REQ-014 Macro CCI_MPF_PRIM_RAM_MULTI_BYPASS_EN SHALL control write-to-read bypass.
- Defined: a write whose address matches a read at the same edge SHALL supply the returned data (write-before-read). A matching write at any later edge while that read is in its pipeline, up to but excluding the response cycle, SHALL also replace the data. The latest matching write wins, independently per port.
- Undefined: no bypass logic is present and REQ-010 applies.

Verification
REQ-015 Directed scenarios the bench SHALL cover:
- Init timing: N_ENTRIES=32, INIT_VALUE=0xA5, reset_n released -> rdy rises exactly 32 cycles later; reading addresses 0..31 on both ports returns 0xA5.
- Latency: N_OUTPUT_REG_STAGES=2; write 0x1234 to address 5; two cycles later ren[1] reads address 5 -> rvalid[1] after exactly 3 edges with rdata[1]=0x1234; rvalid[0] stays 0.
- Collision: same-edge write of 0xBEEF and read of address 7 (old value 0x11) -> returns 0x11 without the macro and 0xBEEF with it.
- Pipeline bypass (macro defined, L=3): read address 9, then writes of 0x1 and 0x2 to address 9 on the next two edges -> returns 0x2.
- Reset mid-flight: reads on both ports in flight, reset_n pulsed low -> no rvalid emitted; rdy low for N_ENTRIES cycles; old data replaced by INIT_VALUE.
- Out of range: N_ENTRIES=24, write of 0xFF to address 30, then read of address 30 -> rvalid=1 with rdata=0; addresses 0..23 unchanged.
